// File: rtl/card_lock_pkg.sv
// Shared types and constants for the card-lock controller: FSM states,
// card-type encodings and datapath widths.
package card_lock_pkg;

    localparam int CODE_W = 16;
    localparam int SW_W   = 18;

    localparam logic [1:0] CT_USER    = 2'b01;
    localparam logic [1:0] CT_PROGRAM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an active-low pushbutton plus a one-cycle pulse
// on each press (high-to-low transition of the synchronized level).
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection; resets to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= key_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/card_lock_controller.sv
// Card-reader door lock: latches a card from the switches, checks it against
// the stored or master code, and drives door, deny, alarm and program outputs.
module card_lock_controller
    import card_lock_pkg::*;
#(
    parameter int unsigned         OPEN_CYCLES    = 100_000_000,
    parameter int unsigned         LOCKOUT_CYCLES = 500_000_000,
    parameter int unsigned         MAX_FAILS      = 3,
    parameter logic [CODE_W-1:0]   RESET_CODE     = 16'h1234,
    parameter logic [CODE_W-1:0]   MASTER_CODE    = 16'hA5A5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] sw,
    input  logic            key_0,
    input  logic            key_1,
    output logic            card_read,
    output logic            door_open,
    output logic            deny,
    output logic            alarm,
    output logic            prog_mode,
    output logic [1:0]      fail_cnt
);

    localparam int unsigned MAX_DWELL  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int          CNT_W      = (MAX_DWELL > 2) ? $clog2(MAX_DWELL) : 1;
    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]       MAX_F     = 2'(MAX_FAILS);

    logic clr_p;
    logic rd_p;

    key_sync_edge u_key_clr (.clk(clk), .rst_n(rst_n), .key_n_i(key_0), .press_o(clr_p));
    key_sync_edge u_key_rd  (.clk(clk), .rst_n(rst_n), .key_n_i(key_1), .press_o(rd_p));

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SW_W-1:0]     card_q, card_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [1:0]          fail_q, fail_d, fail_inc;
    logic                card_read_q, card_read_d;
    logic                deny_q, deny_d;
    logic                door_q, alarm_q, prog_q;

    assign fail_inc = (fail_q == MAX_F) ? MAX_F : fail_q + 2'd1;

    // Next-state, datapath and pulse decode; the dwell counter restarts on any state change.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        card_d      = card_q;
        code_d      = code_q;
        fail_d      = fail_q;
        card_read_d = card_read_q;
        deny_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_p) begin
                    card_read_d = 1'b0;
                end else if (rd_p) begin
                    card_d      = sw;
                    card_read_d = 1'b1;
                    state_d     = ST_CHECK;
                end else begin
                    card_read_d = card_read_q;
                end
            end
            ST_CHECK: begin
                if (card_q[17:16] == CT_USER && card_q[15:0] == code_q) begin
                    fail_d  = 2'd0;
                    state_d = ST_OPEN;
                end else if (card_q[17:16] == CT_PROGRAM && card_q[15:0] == MASTER_CODE) begin
                    fail_d  = 2'd0;
                    state_d = ST_PROGRAM;
                end else begin
                    deny_d      = 1'b1;
                    card_read_d = 1'b0;
                    fail_d      = fail_inc;
                    state_d     = (fail_inc == MAX_F) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (clr_p || cnt_q == OPEN_LAST) begin
                    card_read_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PROGRAM: begin
                if (clr_p) begin
                    card_read_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (rd_p) begin
                    code_d      = sw[15:0];
                    card_read_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_PROGRAM;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    fail_d  = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                card_read_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, datapath and registered outputs; door/alarm/prog follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            card_q      <= {SW_W{1'b0}};
            code_q      <= RESET_CODE;
            fail_q      <= 2'd0;
            card_read_q <= 1'b0;
            deny_q      <= 1'b0;
            door_q      <= 1'b0;
            alarm_q     <= 1'b0;
            prog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            card_q      <= card_d;
            code_q      <= code_d;
            fail_q      <= fail_d;
            card_read_q <= card_read_d;
            deny_q      <= deny_d;
            door_q      <= (state_d == ST_OPEN);
            alarm_q     <= (state_d == ST_LOCKOUT);
            prog_q      <= (state_d == ST_PROGRAM);
        end
    end

    assign card_read = card_read_q;
    assign door_open = door_q;
    assign deny      = deny_q;
    assign alarm     = alarm_q;
    assign prog_mode = prog_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_card_lock_controller.sv
// Directed bench for card_lock_controller with short dwell times.
module tb_card_lock_controller;

    localparam int OPEN_C = 20;
    localparam int LOCK_C = 30;

    logic        clk;
    logic        rst_n;
    logic [17:0] sw;
    logic        key_0;
    logic        key_1;
    logic        card_read;
    logic        door_open;
    logic        deny;
    logic        alarm;
    logic        prog_mode;
    logic [1:0]  fail_cnt;

    int vectors;
    int miscompares;

    card_lock_controller #(
        .OPEN_CYCLES(OPEN_C),
        .LOCKOUT_CYCLES(LOCK_C),
        .MAX_FAILS(3),
        .RESET_CODE(16'h1234),
        .MASTER_CODE(16'hA5A5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .key_0(key_0), .key_1(key_1),
        .card_read(card_read), .door_open(door_open), .deny(deny),
        .alarm(alarm), .prog_mode(prog_mode), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        key_0 = 1'b1;
        key_1 = 1'b1;
        sw    = 18'h0_0000;
        #12;
        chk("rst_outputs", {26'd0, card_read, door_open, deny, alarm, prog_mode, fail_cnt}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_quiet", {26'd0, card_read, door_open, deny, alarm, prog_mode, fail_cnt}, 32'd0);

        // Matching user card: latency and open duration; sw change after latch is ignored
        sw = 18'h1_1234;
        key_1 = 1'b0;
        tick(2);
        chk("user_cr_edge2", {31'd0, card_read}, 32'd0);
        tick(1);
        chk("user_cr_edge3", {31'd0, card_read}, 32'd1);
        chk("user_door_edge3", {31'd0, door_open}, 32'd0);
        sw = 18'h0_0000;
        tick(1);
        chk("user_door_edge4", {31'd0, door_open}, 32'd1);
        key_1 = 1'b1;
        for (int i = 5; i <= OPEN_C + 3; i++) begin
            tick(1);
            chk("user_door_hold", {31'd0, door_open}, 32'd1);
        end
        tick(1);
        chk("user_door_end", {31'd0, door_open}, 32'd0);
        chk("user_cr_end", {31'd0, card_read}, 32'd0);

        // Three mismatches -> lockout
        sw = 18'h1_0000;
        for (int k = 1; k <= 3; k++) begin
            key_1 = 1'b0;
            tick(3);
            chk("bad_cr", {31'd0, card_read}, 32'd1);
            tick(1);
            chk("bad_deny", {31'd0, deny}, 32'd1);
            chk("bad_fail", {30'd0, fail_cnt}, 32'(k));
            chk("bad_cr_clr", {31'd0, card_read}, 32'd0);
            chk("bad_alarm", {31'd0, alarm}, (k == 3) ? 32'd1 : 32'd0);
            key_1 = 1'b1;
            if (k < 3) begin
                tick(1);
                chk("deny_pulse", {31'd0, deny}, 32'd0);
                tick(2);
            end
        end
        for (int i = 1; i < LOCK_C; i++) begin
            if (i == 3) begin
                key_1 = 1'b0;
                key_0 = 1'b0;
            end
            if (i == 8) begin
                key_1 = 1'b1;
                key_0 = 1'b1;
            end
            tick(1);
            chk("lock_alarm", {29'd0, alarm, card_read, deny}, 32'd4);
        end
        tick(1);
        chk("lock_end_alarm", {31'd0, alarm}, 32'd0);
        chk("lock_end_fail", {30'd0, fail_cnt}, 32'd0);
        tick(3);
        chk("lock_after_idle", {31'd0, card_read}, 32'd0);

        // Program card, then new code
        sw = 18'h2_A5A5;
        key_1 = 1'b0;
        tick(4);
        chk("prog_mode", {31'd0, prog_mode}, 32'd1);
        key_1 = 1'b1;
        tick(2);
        sw = 18'h0_BEEF;
        key_1 = 1'b0;
        tick(2);
        chk("prog_hold", {31'd0, prog_mode}, 32'd1);
        tick(1);
        chk("prog_exit", {30'd0, prog_mode, card_read}, 32'd0);
        key_1 = 1'b1;
        tick(2);

        // New code opens; clear press mid-open drops the door
        sw = 18'h1_BEEF;
        key_1 = 1'b0;
        tick(4);
        chk("new_code_open", {31'd0, door_open}, 32'd1);
        key_1 = 1'b1;
        tick(1);
        key_0 = 1'b0;
        tick(2);
        chk("clr_before", {30'd0, door_open, card_read}, 32'd3);
        tick(1);
        chk("clr_after", {30'd0, door_open, card_read}, 32'd0);
        key_0 = 1'b1;
        tick(2);

        // Old code now denied
        sw = 18'h1_1234;
        key_1 = 1'b0;
        tick(4);
        chk("old_code_deny", {29'd0, deny, door_open, 1'b0}, 32'd4);
        chk("old_code_fail", {30'd0, fail_cnt}, 32'd1);
        key_1 = 1'b1;
        tick(2);

        // Simultaneous clear and read in IDLE: no latch
        sw = 18'h1_BEEF;
        key_0 = 1'b0;
        key_1 = 1'b0;
        tick(3);
        chk("both_no_latch", {31'd0, card_read}, 32'd0);
        tick(1);
        chk("both_no_open", {31'd0, door_open}, 32'd0);
        key_0 = 1'b1;
        key_1 = 1'b1;
        tick(2);

        // Async reset mid-open restores the reset code
        key_1 = 1'b0;
        tick(4);
        chk("pre_rst_open", {31'd0, door_open}, 32'd1);
        chk("open_clears_fail", {30'd0, fail_cnt}, 32'd0);
        key_1 = 1'b1;
        tick(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_door", {30'd0, door_open, card_read}, 32'd0);
        tick(1);
        #2;
        rst_n = 1'b1;
        tick(4);
        chk("rst_no_spurious", {30'd0, card_read, door_open}, 32'd0);
        sw = 18'h1_1234;
        key_1 = 1'b0;
        tick(4);
        chk("rst_code_restored", {31'd0, door_open}, 32'd1);
        key_1 = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
